// File: rtl/ps2_pkg.sv
// Shared constants and parse-state type for the PS/2 set-2 key decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        PS_NORMAL = 2'd0,
        PS_E0     = 2'd1,
        PS_F0     = 2'd2,
        PS_E0F0   = 2'd3
    } parse_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
    localparam logic [7:0] PS2_ERR     = 8'hFF;
    localparam logic [7:0] PS2_ERR0    = 8'h00;

    localparam logic [0:0] POP_IDLE = 1'b0;
    localparam logic [0:0] POP_BUSY = 1'b1;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 scan code to ASCII lookup; extended codes give 0x00.
module ps2_scan_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: ascii = 8'h61;
                8'h32: ascii = 8'h62;
                8'h21: ascii = 8'h63;
                8'h23: ascii = 8'h64;
                8'h24: ascii = 8'h65;
                8'h2B: ascii = 8'h66;
                8'h34: ascii = 8'h67;
                8'h33: ascii = 8'h68;
                8'h43: ascii = 8'h69;
                8'h3B: ascii = 8'h6A;
                8'h42: ascii = 8'h6B;
                8'h4B: ascii = 8'h6C;
                8'h3A: ascii = 8'h6D;
                8'h31: ascii = 8'h6E;
                8'h44: ascii = 8'h6F;
                8'h4D: ascii = 8'h70;
                8'h15: ascii = 8'h71;
                8'h2D: ascii = 8'h72;
                8'h1B: ascii = 8'h73;
                8'h2C: ascii = 8'h74;
                8'h3C: ascii = 8'h75;
                8'h2A: ascii = 8'h76;
                8'h1D: ascii = 8'h77;
                8'h22: ascii = 8'h78;
                8'h35: ascii = 8'h79;
                8'h1A: ascii = 8'h7A;
                8'h45: ascii = 8'h30;
                8'h16: ascii = 8'h31;
                8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33;
                8'h25: ascii = 8'h34;
                8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36;
                8'h3D: ascii = 8'h37;
                8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39;
                8'h29: ascii = 8'h20;
                8'h5A: ascii = 8'h0D;
                8'h66: ascii = 8'h08;
                default: ascii = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops bytes from the PS/2 receiver FIFO and tracks the most recent key.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [7:0]         kb_data,
    input  logic               kb_ready,
    input  logic               kb_overflow,
    output logic               kb_nextdata_n,
    output logic               key_down,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic [7:0]         key_ascii,
    output logic [COUNT_W-1:0] press_count,
    output logic               key_event,
    output logic               ovf_sticky
);

    logic [0:0] pop_st;
    logic [7:0] byte_r;
    parse_t     parse_st;
    parse_t     parse_nx;
    logic       do_make;
    logic       do_break;
    logic       cur_ext;
    logic       is_held;
    logic       is_junk;
    logic       is_ext;
    logic       is_brk;
    logic [7:0] ascii_w;

    assign is_ext  = (byte_r == PS2_PFX_EXT);
    assign is_brk  = (byte_r == PS2_PFX_BRK);
    assign is_junk = (byte_r == PS2_ERR0) || (byte_r == PS2_BAT_OK)
                  || (byte_r == PS2_ERR);

    always_comb begin
        parse_nx = parse_st;
        do_make  = 1'b0;
        do_break = 1'b0;
        cur_ext  = 1'b0;
        unique case (parse_st)
            PS_NORMAL: begin
                if (is_ext)       parse_nx = PS_E0;
                else if (is_brk)  parse_nx = PS_F0;
                else if (!is_junk) do_make = 1'b1;
            end
            PS_E0: begin
                cur_ext = 1'b1;
                if (is_brk)      parse_nx = PS_E0F0;
                else if (!is_ext) begin
                    do_make  = 1'b1;
                    parse_nx = PS_NORMAL;
                end
            end
            PS_F0: begin
                if (is_ext)      parse_nx = PS_E0F0;
                else if (!is_brk) begin
                    do_break = 1'b1;
                    parse_nx = PS_NORMAL;
                end
            end
            PS_E0F0: begin
                cur_ext = 1'b1;
                if (!is_ext && !is_brk) begin
                    do_break = 1'b1;
                    parse_nx = PS_NORMAL;
                end
            end
            default: parse_nx = PS_NORMAL;
        endcase
    end

    // A make of the held key is typematic; a break must match the held key.
    assign is_held = key_down && (key_code == byte_r) && (key_ext == cur_ext);

    ps2_scan_to_ascii u_rom (
        .code  (byte_r),
        .ext   (cur_ext),
        .ascii (ascii_w)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pop_st        <= POP_IDLE;
            byte_r        <= 8'h00;
            parse_st      <= PS_NORMAL;
            kb_nextdata_n <= 1'b1;
            key_down      <= 1'b0;
            key_code      <= 8'h00;
            key_ext       <= 1'b0;
            key_ascii     <= 8'h00;
            press_count   <= '0;
            key_event     <= 1'b0;
            ovf_sticky    <= 1'b0;
        end else begin
            key_event  <= 1'b0;
            ovf_sticky <= ovf_sticky | kb_overflow;
            if (pop_st == POP_IDLE) begin
                if (kb_ready) begin
                    byte_r        <= kb_data;
                    pop_st        <= POP_BUSY;
                    kb_nextdata_n <= 1'b0;
                end
            end else begin
                pop_st        <= POP_IDLE;
                kb_nextdata_n <= 1'b1;
                parse_st      <= parse_nx;
                if (do_make && !is_held) begin
                    key_down    <= 1'b1;
                    key_code    <= byte_r;
                    key_ext     <= cur_ext;
                    key_ascii   <= ascii_w;
                    press_count <= press_count + 1'b1;
                    key_event   <= 1'b1;
                end else if (do_break && is_held) begin
                    key_down  <= 1'b0;
                    key_event <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against a prefix-flag model.
module tb_ps2_key_decoder;

    logic       clock;
    logic       resetn;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_nextdata_n;
    logic       key_down;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] key_ascii;
    logic [7:0] press_count;
    logic       key_event;
    logic       ovf_sticky;

    int vectors;
    int miscompares;
    int ev_total;

    ps2_key_decoder #(.COUNT_W(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_overflow   (kb_overflow),
        .kb_nextdata_n (kb_nextdata_n),
        .key_down      (key_down),
        .key_code      (key_code),
        .key_ext       (key_ext),
        .key_ascii     (key_ascii),
        .press_count   (press_count),
        .key_event     (key_event),
        .ovf_sticky    (ovf_sticky)
    );

    always #5 clock = ~clock;

    logic [7:0] letters [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    // Reference model: pending prefix flags rather than a state machine
    logic       m_down, m_ext, m_ev, m_pext, m_pbrk;
    logic [7:0] m_code, m_ascii, m_cnt;

    logic       obs_pop, obs_nd2, obs_down, obs_ext, obs_ev;
    logic [7:0] obs_code, obs_ascii, obs_cnt;

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic e);
        logic [7:0] r;
        r = 8'h00;
        if (!e) begin
            for (int i = 0; i < 26; i++) if (letters[i] == c) r = 8'h61 + 8'(i);
            for (int i = 0; i < 10; i++) if (digits[i] == c) r = 8'h30 + 8'(i);
            if (c == 8'h29) r = 8'h20;
            if (c == 8'h5A) r = 8'h0D;
            if (c == 8'h66) r = 8'h08;
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_down = 0; m_ext = 0; m_ev = 0; m_pext = 0; m_pbrk = 0;
        m_code = 0; m_ascii = 0; m_cnt = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic held;
        m_ev = 0;
        if (b == 8'hE0) m_pext = 1;
        else if (b == 8'hF0) m_pbrk = 1;
        else if (!m_pext && !m_pbrk && (b == 8'h00 || b == 8'hAA || b == 8'hFF)) m_ev = 0;
        else begin
            held = m_down && (m_code == b) && (m_ext == m_pext);
            if (!m_pbrk) begin
                if (!held) begin
                    m_down = 1; m_code = b; m_ext = m_pext;
                    m_ascii = ref_ascii(b, m_pext);
                    m_cnt = m_cnt + 8'd1; m_ev = 1;
                end
            end else if (held) begin
                m_down = 0; m_ev = 1;
            end
            m_pext = 0; m_pbrk = 0;
        end
    endfunction

    task automatic push(input logic [7:0] b);
        @(posedge clock); #1;
        kb_ready = 1; kb_data = b;
        @(posedge clock); #1;
        kb_ready = 0; kb_data = 8'($urandom);
        @(negedge clock);
        obs_pop = kb_nextdata_n;
        model_byte(b);
        @(negedge clock);
        obs_nd2 = kb_nextdata_n; obs_down = key_down; obs_code = key_code;
        obs_ext = key_ext; obs_ascii = key_ascii; obs_cnt = press_count;
        obs_ev = key_event;
        ev_total += int'(key_event);
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({kb_nextdata_n, key_down, key_code, key_ext, key_ascii, press_count, key_event, ovf_sticky}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_in: nd=%b dn=%b code=%h ext=%b asc=%h cnt=%h ev=%b ovf=%b want 1 0 00 0 00 00 0 0",
                kb_nextdata_n, key_down, key_code, key_ext, key_ascii, press_count, key_event, ovf_sticky);
        end
        @(posedge clock); #1; resetn = 1;
        model_reset();
        repeat (2) @(negedge clock);
        vectors++;
        if ({kb_nextdata_n, key_down, key_event, press_count} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_out: nd=%b dn=%b ev=%b cnt=%h want 1 0 0 00",
                kb_nextdata_n, key_down, key_event, press_count);
        end
    endtask

    task automatic test_make();
        ev_total = 0;
        push(8'h1C);
        vectors++;
        if ({obs_pop, obs_nd2} !== 2'b01) begin
            miscompares++;
            $display("FAIL make_pop: strobe=%b after=%b want 0 1", obs_pop, obs_nd2);
        end
        vectors++;
        if ({obs_down, obs_code, obs_ascii, obs_cnt, obs_ev} !== {1'b1, 8'h1C, 8'h61, 8'h01, 1'b1}) begin
            miscompares++;
            $display("FAIL make_1c: dn=%b code=%h asc=%h cnt=%h ev=%b want 1 1c 61 01 1",
                obs_down, obs_code, obs_ascii, obs_cnt, obs_ev);
        end
    endtask

    task automatic test_typematic();
        push(8'h1C); push(8'h1C); push(8'h1C);
        vectors++;
        if ({obs_down, obs_cnt} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL typematic_hold: dn=%b cnt=%h want 1 01", obs_down, obs_cnt);
        end
        push(8'hF0); push(8'h1C);
        vectors++;
        if ({obs_down, obs_code, obs_cnt} !== {1'b0, 8'h1C, 8'h01}) begin
            miscompares++;
            $display("FAIL typematic_break: dn=%b code=%h cnt=%h want 0 1c 01", obs_down, obs_code, obs_cnt);
        end
        vectors++;
        if (ev_total !== 2) begin
            miscompares++;
            $display("FAIL typematic_events: got %0d want 2", ev_total);
        end
    endtask

    task automatic test_extended();
        push(8'hE0); push(8'h75);
        vectors++;
        if ({obs_down, obs_ext, obs_code, obs_ascii, obs_cnt} !== {1'b1, 1'b1, 8'h75, 8'h00, 8'h02}) begin
            miscompares++;
            $display("FAIL ext_make: dn=%b ext=%b code=%h asc=%h cnt=%h want 1 1 75 00 02",
                obs_down, obs_ext, obs_code, obs_ascii, obs_cnt);
        end
        push(8'hF0); push(8'h75);
        vectors++;
        if ({obs_down, obs_ev} !== 2'b10) begin
            miscompares++;
            $display("FAIL ext_plain_break: dn=%b ev=%b want 1 0", obs_down, obs_ev);
        end
        push(8'hE0); push(8'hF0); push(8'h75);
        vectors++;
        if ({obs_down, obs_ext, obs_code, obs_ev} !== {1'b0, 1'b1, 8'h75, 1'b1}) begin
            miscompares++;
            $display("FAIL ext_break: dn=%b ext=%b code=%h ev=%b want 0 1 75 1",
                obs_down, obs_ext, obs_code, obs_ev);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [16] = '{
            8'h1C, 8'h1A, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h75,
            8'h6B, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'h00, 8'hFF, 8'h24};
        logic [7:0] b;
        for (int i = 0; i < 80; i++) begin
            b = pool[$urandom_range(0, 15)];
            push(b);
            vectors++;
            if ({obs_pop, obs_nd2} !== 2'b01) begin
                miscompares++;
                $display("FAIL rnd_pop[%0d]: strobe=%b after=%b want 0 1", i, obs_pop, obs_nd2);
            end
            vectors++;
            if ({obs_down, obs_code, obs_ext, obs_ascii, obs_cnt, obs_ev}
                !== {m_down, m_code, m_ext, m_ascii, m_cnt, m_ev}) begin
                miscompares++;
                $display("FAIL rnd_state[%0d] byte %h: got dn=%b code=%h ext=%b asc=%h cnt=%h ev=%b want %b %h %b %h %h %b",
                    i, b, obs_down, obs_code, obs_ext, obs_ascii, obs_cnt, obs_ev,
                    m_down, m_code, m_ext, m_ascii, m_cnt, m_ev);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [$];
        logic [7:0] c;
        logic [7:0] d;
        logic nd, prev_low;
        int strobes, doubles, evs, exp_ev;
        c = letters[$urandom_range(0, 25)];
        d = digits[$urandom_range(0, 9)];
        q = '{c, 8'hF0, c, d, 8'hE0, 8'h75};
        exp_ev = 0;
        foreach (q[k]) begin
            model_byte(q[k]);
            exp_ev += int'(m_ev);
        end
        strobes = 0; doubles = 0; evs = 0; prev_low = 0;
        @(posedge clock); #1;
        kb_ready = 1; kb_data = q[0];
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            nd = kb_nextdata_n;
            evs += int'(key_event);
            if (!nd) begin
                strobes++;
                if (prev_low) doubles++;
            end
            prev_low = !nd;
            @(posedge clock); #1;
            if (!nd && q.size() > 0) void'(q.pop_front());
            kb_ready = (q.size() > 0);
            if (q.size() > 0) kb_data = q[0];
        end
        vectors++;
        if (strobes !== 6 || doubles !== 0) begin
            miscompares++;
            $display("FAIL b2b_strobes: got %0d strobes %0d doubles want 6 0", strobes, doubles);
        end
        vectors++;
        if (evs !== exp_ev) begin
            miscompares++;
            $display("FAIL b2b_events: got %0d want %0d", evs, exp_ev);
        end
        vectors++;
        if ({key_down, key_code, key_ext, key_ascii, press_count}
            !== {m_down, m_code, m_ext, m_ascii, m_cnt}) begin
            miscompares++;
            $display("FAIL b2b_state: dn=%b code=%h ext=%b asc=%h cnt=%h want %b %h %b %h %h",
                key_down, key_code, key_ext, key_ascii, press_count,
                m_down, m_code, m_ext, m_ascii, m_cnt);
        end
    endtask

    task automatic test_wrap();
        @(posedge clock); #1; resetn = 0;
        @(posedge clock); #1; resetn = 1;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            push((i % 2 == 1) ? 8'h1E : 8'h16);
            vectors++;
            if ({obs_ascii, obs_cnt} !== {((i % 2 == 1) ? 8'h32 : 8'h31), m_cnt}) begin
                miscompares++;
                $display("FAIL wrap[%0d]: asc=%h cnt=%h want %h %h",
                    i, obs_ascii, obs_cnt, ((i % 2 == 1) ? 8'h32 : 8'h31), m_cnt);
            end
        end
        vectors++;
        if (obs_cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL wrap_zero: cnt=%h want 00", obs_cnt);
        end
    endtask

    task automatic test_overflow_reset();
        push(8'h24);
        @(posedge clock); #1; kb_overflow = 1;
        @(posedge clock); #1; kb_overflow = 0;
        @(negedge clock);
        vectors++;
        if (ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: ovf=%b want 1", ovf_sticky);
        end
        repeat (4) @(negedge clock);
        vectors++;
        if (ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_hold: ovf=%b want 1", ovf_sticky);
        end
        @(posedge clock); #1;
        kb_ready = 1; kb_data = 8'h1A;
        @(posedge clock); #1;
        kb_ready = 0;
        @(negedge clock);
        vectors++;
        if (kb_nextdata_n !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pre_pop: nd=%b want 0", kb_nextdata_n);
        end
        #2 resetn = 0;
        #1;
        vectors++;
        if ({kb_nextdata_n, key_down, key_code, key_ext, key_ascii, press_count, key_event, ovf_sticky}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_pop: nd=%b dn=%b code=%h ext=%b asc=%h cnt=%h ev=%b ovf=%b want 1 0 00 0 00 00 0 0",
                kb_nextdata_n, key_down, key_code, key_ext, key_ascii, press_count, key_event, ovf_sticky);
        end
        @(posedge clock); #1; resetn = 1;
        model_reset();
        repeat (4) @(negedge clock);
        vectors++;
        if ({kb_nextdata_n, key_down, press_count, ovf_sticky} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_discard: nd=%b dn=%b cnt=%h ovf=%b want 1 0 00 0",
                kb_nextdata_n, key_down, press_count, ovf_sticky);
        end
        push(8'h1C);
        vectors++;
        if ({obs_down, obs_code, obs_cnt} !== {1'b1, 8'h1C, 8'h01}) begin
            miscompares++;
            $display("FAIL rst_resume: dn=%b code=%h cnt=%h want 1 1c 01", obs_down, obs_code, obs_cnt);
        end
    endtask

    initial begin
        clock = 0; resetn = 0; kb_ready = 0; kb_data = 8'h00; kb_overflow = 0;
        vectors = 0; miscompares = 0; ev_total = 0;
        model_reset();
        test_reset();
        test_make();
        test_typematic();
        test_extended();
        test_random();
        test_back_to_back();
        test_wrap();
        test_overflow_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
